// File: rtl/adder_rr_sched_pkg.sv
// Shared definitions for the round-robin serial adder: slice width,
// FSM state encoding and the slice-count derivation.
package adder_rr_sched_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice cycles needed for one operand width.
  function automatic int nslice(input int data_w);
    return data_w / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_rr_sched_fa_8b.sv
// One 8-bit ripple-carry adder slice built from per-bit full adders.
// This is the only adder in the scheduler; the top time-shares it.
module fa_8b
  import adder_rr_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  // Ripple the carry bit by bit through the slice.
  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler that shares one 8-bit adder slice between two
// requesters, computing a DATA_W-bit sum one slice per clock.
module adder_rr_sched #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_dataA,
  input  logic [DATA_W-1:0] i_req0_dataB,
  input  logic              i_req0_cin,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_dataA,
  input  logic [DATA_W-1:0] i_req1_dataB,
  input  logic              i_req1_cin,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_sum,
  output logic              o_rsp_cout,
  output logic              o_busy
);
  import adder_rr_sched_pkg::*;

  localparam int NSLICE = nslice(DATA_W);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SW_LOG = $clog2(SLICE_W);

  state_t              state;
  logic [KW-1:0]       k;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                cin_q;
  logic                carry_q;
  logic [DATA_W-1:0]   sum_q;
  logic                id_q;
  logic                ptr;
  logic                rsp_valid_q;
  logic                busy_q;

  logic                grant_id;
  logic                accept;
  logic [KW+SW_LOG-1:0] base;
  logic                slice_cin;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_id     = 1'b0;
    accept       = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_id = ~ptr;
    end else if (i_req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
    if ((state == IDLE) && !i_rst) begin
      accept       = i_req0_valid | i_req1_valid;
      o_req0_ready = i_req0_valid & (grant_id == 1'b0);
      o_req1_ready = i_req1_valid & (grant_id == 1'b1);
    end else begin
      accept       = 1'b0;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
    end
  end

  // Slice select: first slice takes the latched carry-in, later ones the carry register.
  always_comb begin
    base = {k, {SW_LOG{1'b0}}};
    if (k == '0) begin
      slice_cin = cin_q;
    end else begin
      slice_cin = carry_q;
    end
  end

  fa_8b u_fa (
    .a    (a_q[base +: SLICE_W]),
    .b    (b_q[base +: SLICE_W]),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Control FSM with latched operands and registered response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      id_q        <= 1'b0;
      ptr         <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= grant_id ? i_req1_dataA : i_req0_dataA;
            b_q     <= grant_id ? i_req1_dataB : i_req0_dataB;
            cin_q   <= grant_id ? i_req1_cin   : i_req0_cin;
            id_q    <= grant_id;
            ptr     <= grant_id;
            k       <= '0;
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          sum_q[base +: SLICE_W] <= slice_sum;
          carry_q                <= slice_cout;
          k                      <= k + KW'(1);
          if (k == KW'(NSLICE - 1)) begin
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_sum   = sum_q;
  assign o_rsp_cout  = carry_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Self-checking bench for adder_rr_sched: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_adder_rr_sched;

  localparam int DATA_W = 32;
  localparam int NSLICE = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_req0_valid = 1'b0;
  logic              o_req0_ready;
  logic [DATA_W-1:0] i_req0_dataA = '0;
  logic [DATA_W-1:0] i_req0_dataB = '0;
  logic              i_req0_cin = 1'b0;
  logic              i_req1_valid = 1'b0;
  logic              o_req1_ready;
  logic [DATA_W-1:0] i_req1_dataA = '0;
  logic [DATA_W-1:0] i_req1_dataB = '0;
  logic              i_req1_cin = 1'b0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic              o_rsp_id;
  logic [DATA_W-1:0] o_rsp_sum;
  logic              o_rsp_cout;
  logic              o_busy;

  adder_rr_sched #(.DATA_W(DATA_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_dataA (i_req0_dataA),
    .i_req0_dataB (i_req0_dataB),
    .i_req0_cin   (i_req0_cin),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_dataA (i_req1_dataA),
    .i_req1_dataB (i_req1_dataB),
    .i_req1_cin   (i_req1_cin),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_sum    (o_rsp_sum),
    .o_rsp_cout   (o_rsp_cout),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model, transaction level: phase 0 idle, 1 computing, 2 holding result.
  int              m_phase;
  int              m_left;
  logic            m_last;
  logic            m_id;
  logic [DATA_W-1:0] m_sum;
  logic            m_cout;
  int              m_ids[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_last  = 1'b1;
    m_id    = 1'b0;
    m_sum   = '0;
    m_cout  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model after the rising edge.
  task automatic step(input logic v0, input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] b0,
                      input logic c0, input logic v1, input logic [DATA_W-1:0] a1,
                      input logic [DATA_W-1:0] b1, input logic c1, input logic rr);
    logic          winner;
    logic [DATA_W:0] full;
    i_req0_valid = v0; i_req0_dataA = a0; i_req0_dataB = b0; i_req0_cin = c0;
    i_req1_valid = v1; i_req1_dataA = a1; i_req1_dataB = b1; i_req1_cin = c1;
    i_rsp_ready  = rr;
    winner = (v0 && v1) ? ~m_last : v1;
    @(negedge i_clk);
    check_eq("ready0", 64'(o_req0_ready), 64'(m_phase == 0 && v0 && !winner));
    check_eq("ready1", 64'(o_req1_ready), 64'(m_phase == 0 && v1 && winner));
    check_eq("rsp_valid", 64'(o_rsp_valid), 64'(m_phase == 2));
    check_eq("busy", 64'(o_busy), 64'(m_phase != 0));
    if (m_phase == 2) begin
      check_eq("rsp_sum", 64'(o_rsp_sum), 64'(m_sum));
      check_eq("rsp_cout", 64'(o_rsp_cout), 64'(m_cout));
      check_eq("rsp_id", 64'(o_rsp_id), 64'(m_id));
    end
    @(posedge i_clk);
    #1;
    if (m_phase == 0) begin
      if (v0 || v1) begin
        full   = winner ? ({1'b0, a1} + {1'b0, b1} + (DATA_W+1)'(c1))
                        : ({1'b0, a0} + {1'b0, b0} + (DATA_W+1)'(c0));
        m_sum  = full[DATA_W-1:0];
        m_cout = full[DATA_W];
        m_id   = winner;
        m_last = winner;
        m_left = NSLICE;
        m_phase = 1;
        m_ids.push_back(winner);
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else begin
      if (rr) m_phase = 0;
    end
  endtask

  task automatic idle_cycle(input logic rr);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rr);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset_check();
    #2;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_rst = 1'b1;
    #1;
    check_eq("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_sum", 64'(o_rsp_sum), 64'd0);
    check_eq("rst_cout", 64'(o_rsp_cout), 64'd0);
    check_eq("rst_id", 64'(o_rsp_id), 64'd0);
    check_eq("rst_ready0", 64'(o_req0_ready), 64'd0);
    check_eq("rst_ready1", 64'(o_req1_ready), 64'd0);
    model_reset();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  logic [DATA_W-1:0] ra0, rb0, ra1, rb1;
  int guard;
  int wait0, wait1;

  initial begin
    model_reset();
    // Initial reset and reset-state checks
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_eq("reset_busy", 64'(o_busy), 64'd0);
    check_eq("reset_sum", 64'(o_rsp_sum), 64'd0);
    check_eq("reset_cout", 64'(o_rsp_cout), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // 1: carry across the first slice boundary from requester 0
    step(1'b1, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < NSLICE + 1; i++) idle_cycle(1'b1);
    check_eq("t1_sum", 64'(m_sum), 64'h0000_0100);

    // 2: carry rippling through every slice from requester 1
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    for (int i = 0; i < NSLICE + 1; i++) idle_cycle(1'b1);

    // 3/4: both requesters hold valid continuously; grants must alternate
    m_ids.delete();
    for (int i = 0; i < 4 * (NSLICE + 2); i++)
      step(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b1);
    check_eq("alt_count", 64'(m_ids.size()), 64'd4);
    check_eq("alt_first", 64'(m_ids[0]), 64'd0);
    check_eq("alt_second", 64'(m_ids[1]), 64'd1);
    for (int i = 0; i < NSLICE + 2; i++) idle_cycle(1'b1);

    // 5: consumer stalls for 10 cycles in DONE while both requesters wait
    step(1'b1, 32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < NSLICE + 10; i++)
      step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5, 32'h6, 1'b0, 1'b1);
    for (int i = 0; i < NSLICE + 2; i++) idle_cycle(1'b1);

    // 6: reset in the middle of an operation, then confirm the pointer reset
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b1);
    guard = 0;
    while (!(m_phase == 1 && m_left == NSLICE - 2) && guard < 20) begin
      idle_cycle(1'b1);
      guard++;
    end
    check_eq("reach_k2", 64'(guard < 20), 64'd1);
    async_reset_check();
    for (int i = 0; i < NSLICE + 2; i++) idle_cycle(1'b1);
    step(1'b1, 32'h1, 32'h2, 1'b0, 1'b1, 32'h3, 32'h4, 1'b0, 1'b1);
    check_eq("post_rst_tie", 64'(m_id), 64'd0);
    for (int i = 0; i < NSLICE + 1; i++) idle_cycle(1'b1);

    // Random traffic; operands change every cycle to exercise the latched copies
    m_ids.delete();
    wait0 = 0;
    wait1 = 0;
    for (int i = 0; i < 600; i++) begin
      ra0 = $urandom(); rb0 = $urandom(); ra1 = $urandom(); rb1 = $urandom();
      if (($urandom() & 32'd7) == 32'd0) begin ra0 = 32'hFFFFFFFF; rb0 = 32'h0; end
      step(($urandom() & 32'd3) != 32'd0, ra0, rb0, 1'($urandom()),
           ($urandom() & 32'd3) != 32'd0, ra1, rb1, 1'($urandom()),
           ($urandom() & 32'd3) != 32'd0);
    end
    for (int i = 0; i < 3 * NSLICE; i++) idle_cycle(1'b1);
    check_eq("rand_drained", 64'(o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler sharing one 8-bit ripple adder slice (fa_8b) between two requesters.
- Performs DATA_W-bit additions serially: one 8-bit slice per clock, with the carry held in a register between slices.
- Sits between operand producers and the counter/accumulator logic. It trades throughput for area: one adder slice instead of a full DATA_W-bit chain.

Parameters:
- DATA_W, 32, operand/sum width; must be a multiple of 8, minimum 8.
- NSLICE, DATA_W/8, derived: number of slice cycles per operation. Not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req0_valid  input  1  requester 0 has an operation pending.
- o_req0_ready  output  1  requester 0 operation accepted this cycle.
- i_req0_dataA  input  DATA_W  requester 0 operand A.
- i_req0_dataB  input  DATA_W  requester 0 operand B.
- i_req0_cin  input  1  requester 0 carry-in.
- i_req1_valid, o_req1_ready, i_req1_dataA, i_req1_dataB, i_req1_cin: same as requester 0, for requester 1.
- o_rsp_valid  output  1  result available.
- i_rsp_ready  input  1  consumer takes the result.
- o_rsp_id  output  1  requester index owning the result.
- o_rsp_sum  output  DATA_W  sum.
- o_rsp_cout  output  1  carry-out of the MSB slice.
- o_busy  output  1  high in BUSY or DONE.

Behaviour:
- States:
  - IDLE: accepts new work.
  - BUSY: slice counter k runs 0..NSLICE-1.
  - DONE: result is held.
- Reset (async, immediate):
  - State = IDLE; all outputs 0.
  - Operand/sum/carry registers = 0; k = 0.
  - Round-robin last-grant pointer = 1, so requester 0 wins the first tie.
- Grant (combinational, IDLE only):
  - If exactly one valid, grant that requester.
  - If both valid, grant the requester not equal to the pointer.
  - o_reqN_ready = (state==IDLE) & grant==N. Ready depends on valid; a requester must not make valid depend on ready.
- Accept edge (valid&ready):
  - Latch A, B, cin and id.
  - Pointer = granted id; k = 0; go to BUSY.
- Operand hold: the requester may change operands after the accept edge; only latched copies are used.
- BUSY, each edge:
  - fa_8b adds slice k of A and B, with cin = the latched cin when k==0, otherwise the carry register.
  - The 8-bit result is written into sum[8k+7:8k]; the carry register takes the slice cout; k increments.
  - At k==NSLICE-1, go to DONE.
- Latency: o_rsp_valid goes high NSLICE edges after the accept edge (4 for DATA_W=32).
- DONE:
  - o_rsp_valid=1; o_rsp_sum, o_rsp_cout and o_rsp_id are held stable until i_rsp_ready=1.
  - On that edge, return to IDLE and clear o_rsp_valid.
  - No new accept in the same cycle; the next accept is possible one cycle later.
- Throughput: at most one operation per NSLICE+2 cycles.
- o_rsp_sum/o_rsp_cout are registered outputs. Their value outside DONE is don't-care for the consumer, but must not be X after reset.
- Arithmetic: sum = (A + B + cin) mod 2^DATA_W; cout = bit DATA_W of the full result.
- Valid dropped while not granted: no effect, no state kept.
- Reset mid-BUSY or mid-DONE: operation discarded, no response after reset release, pointer reset.
- DATA_W=8: NSLICE=1, a single BUSY cycle.

Decomposition:
- Shared package holds:
  - SLICE_W=8;
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the NSLICE derivation function.
- One sub-module only: a single fa_8b instance as the slice datapath, with no other adders inside the block.
- Slice select and insert via indexed part-select on k.

Test Plan:
1. Reset, then req0 A=0x000000FF B=0x00000001 cin=0:
   - ready0 high 1 cycle; o_rsp_valid rises 4 edges after accept;
   - sum=0x00000100, cout=0, id=0.
2. req1 A=0xFFFFFFFF B=0x00000000 cin=1 -> carry ripples through all 4 slices; sum=0x00000000, cout=1, id=1.
3. Both valids high from reset, A=0x12345678 B=0x11111111 for both, rsp_ready=1:
   - first response id=0 sum=0x23456789;
   - req1 stays valid and gets ready after the response cycle plus one; second response id=1.
4. Both valid continuously for 4 operations -> rsp_id sequence 0,1,0,1; no requester waits more than one operation.
5. i_rsp_ready=0 for 10 cycles in DONE:
   - o_rsp_valid, sum, cout and id stay stable; both readys stay 0;
   - rsp_ready=1 -> IDLE next edge.
6. i_rst pulsed during BUSY at k=2 (no clock edge needed):
   - all outputs 0 immediately; no o_rsp_valid after release;
   - next tie grants req0.
